// File: rtl/cavlc_pkg.sv
// rtl/cavlc_pkg.sv - shared widths and FSM state type for the CAVLC bitstream packer
package cavlc_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_ACC_W  = 256;
    localparam int DEF_CNT_W  = 24;
    localparam int CODE_W     = 128;
    localparam int CODE_BIT_W = 7;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STOP  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pack_state_e;

endpackage

// File: rtl/cavlc_bitstream_packer_if.sv
// rtl/cavlc_bitstream_packer_if.sv - code input, flush and word output handshakes of the packer
//   Code input : cavlc_enc_valid / packer_ready with cavlc_bitstream_code, cavlc_bitstream_bit
//   Flush      : flush_i / flush_ready_o, completion pulse flush_done_o
//   Word output: word_o / word_valid_o / word_ready_i
//   master = encoder + downstream writer side, slave = packer side
interface cavlc_bitstream_packer_if
    import cavlc_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic                  cavlc_enc_valid;
    logic [CODE_W-1:0]     cavlc_bitstream_code;
    logic [CODE_BIT_W-1:0] cavlc_bitstream_bit;
    logic                  packer_ready;
    logic                  flush_i;
    logic                  flush_ready_o;
    logic                  flush_done_o;
    logic [WORD_W-1:0]     word_o;
    logic                  word_valid_o;
    logic                  word_ready_i;

    modport master (
        output cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush_i, word_ready_i,
        input  packer_ready, flush_ready_o, flush_done_o, word_o, word_valid_o
    );

    modport slave (
        input  cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush_i, word_ready_i,
        output packer_ready, flush_ready_o, flush_done_o, word_o, word_valid_o
    );
endinterface

// File: rtl/cavlc_bit_shifter.sv
// rtl/cavlc_bit_shifter.sv - places a right-aligned code at a bit offset below the accumulator MSB
//   code   : right-aligned code, only the low nbits are used
//   nbits  : number of code bits, 0..127
//   offset : position of the first code bit counted down from ACC_W-1
//   mask   : ACC_W-wide OR-mask holding the placed code, all other bits zero
module cavlc_bit_shifter
    import cavlc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OFF_W = $clog2(ACC_W + 1)
) (
    input  logic [CODE_W-1:0]     code,
    input  logic [CODE_BIT_W-1:0] nbits,
    input  logic [OFF_W-1:0]      offset,
    output logic [ACC_W-1:0]      mask
);
    localparam int LEAD_W = CODE_BIT_W + 1;

    logic [CODE_W-1:0] keep;
    logic [ACC_W-1:0]  ext;
    logic [LEAD_W-1:0] lead;

    always_comb begin
        // Bits above nbits are don't-care on the input and must not leak into the stream.
        keep = (CODE_W'(1) << nbits) - CODE_W'(1);
        ext  = {code & keep, {(ACC_W - CODE_W){1'b0}}};
        // Left shift MSB-aligns the first code bit, right shift moves it to the offset.
        lead = LEAD_W'(CODE_W) - {1'b0, nbits};
        mask = (ext << lead) >> offset;
    end
endmodule

// File: rtl/cavlc_bitstream_packer.sv
// rtl/cavlc_bitstream_packer.sv - packs variable-length CAVLC codes MSB-first into fixed-width RBSP words
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : code input, flush request/done and word output handshakes
//   total_bytes_o : bytes emitted since reset, wraps silently
module cavlc_bitstream_packer
    import cavlc_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    cavlc_bitstream_packer_if.slave  bus,
    output logic [CNT_W-1:0]         total_bytes_o
);
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam logic [FILL_W-1:0] WORD_F     = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] PUSH_LIMIT = FILL_W'(ACC_W - CODE_W);
    localparam logic [FILL_W-1:0] STOP_LIMIT = FILL_W'(ACC_W - WORD_W);

    pack_state_e           state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d, acc_pop, place_mask;
    logic [FILL_W-1:0]     fill_q, fill_d, fill_pop, fill_pad;
    logic [CNT_W-1:0]      total_q;
    logic                  pop, push, stop_fit;
    logic [CODE_W-1:0]     sh_code;
    logic [CODE_BIT_W-1:0] sh_bits;

    // In STOP the shifter is reused to place the single rbsp stop bit.
    cavlc_bit_shifter #(.ACC_W(ACC_W), .OFF_W(FILL_W)) u_shifter (
        .code   (sh_code),
        .nbits  (sh_bits),
        .offset (fill_pop),
        .mask   (place_mask)
    );

    always_comb begin
        bus.word_valid_o  = (fill_q >= WORD_F) || (state_q == DRAIN && fill_q != '0);
        bus.word_o        = acc_q[ACC_W-1 -: WORD_W];
        pop               = bus.word_valid_o && bus.word_ready_i;
        fill_pop          = pop ? fill_q - WORD_F : fill_q;
        acc_pop           = pop ? acc_q << WORD_W : acc_q;
        bus.packer_ready  = (state_q == RUN) && (fill_pop <= PUSH_LIMIT);
        bus.flush_ready_o = (state_q == RUN) && !bus.cavlc_enc_valid;
        bus.flush_done_o  = (state_q == DONE);
        push              = bus.cavlc_enc_valid && bus.packer_ready;
        stop_fit          = (state_q == STOP) && (fill_pop <= STOP_LIMIT);
        // Stop bit plus zero padding: next word boundary strictly above fill_pop.
        fill_pad          = (fill_pop / WORD_F + FILL_W'(1)) * WORD_F;
        sh_code           = (state_q == STOP) ? CODE_W'(1) : bus.cavlc_bitstream_code;
        sh_bits           = (state_q == STOP) ? CODE_BIT_W'(1) : bus.cavlc_bitstream_bit;

        state_d = state_q;
        acc_d   = acc_pop;
        fill_d  = fill_pop;
        case (state_q)
            RUN: begin
                if (push) begin
                    acc_d  = acc_pop | place_mask;
                    fill_d = fill_pop + FILL_W'(bus.cavlc_bitstream_bit);
                end else if (bus.flush_i && bus.flush_ready_o) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (stop_fit) begin
                    acc_d   = acc_pop | place_mask;
                    fill_d  = fill_pad;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fill_q == '0) state_d = DONE;
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            acc_q   <= '0;
            fill_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            if (pop) total_q <= total_q + CNT_W'(WORD_W / 8);
        end
    end

    assign total_bytes_o = total_q;
endmodule

// File: tb/tb_cavlc_bitstream_packer.sv
// tb/tb_cavlc_bitstream_packer.sv - scoreboard bench for cavlc_bitstream_packer
module tb_cavlc_bitstream_packer;
    localparam int WORD_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] total_bytes;
    int          rdy_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random

    int vectors = 0;
    int miscompares = 0;

    bit mq[$];          // expected stream bits, earliest first
    int model_bits = 0; // stream bits since reset, including stop bit and padding

    cavlc_bitstream_packer_if #(.WORD_W(WORD_W)) bus ();

    cavlc_bitstream_packer #(.WORD_W(WORD_W), .ACC_W(256), .CNT_W(24)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .total_bytes_o (total_bytes)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.word_ready_i = 1'b0;
            1:       bus.word_ready_i = 1'b1;
            default: bus.word_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference: each accepted code appends its bits; a flush appends '1' and zeros to a word boundary.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cavlc_enc_valid && bus.packer_ready) begin
                for (int i = int'(bus.cavlc_bitstream_bit) - 1; i >= 0; i--)
                    mq.push_back(bus.cavlc_bitstream_code[i]);
                model_bits += int'(bus.cavlc_bitstream_bit);
            end
            if (bus.flush_i && bus.flush_ready_o) begin
                mq.push_back(1'b1);
                model_bits++;
                while (model_bits % WORD_W != 0) begin
                    mq.push_back(1'b0);
                    model_bits++;
                end
            end
        end
    end

    // Output monitor: every word handed off must equal the next WORD_W model bits.
    always @(negedge clk) begin
        logic [WORD_W-1:0] exp_w;
        if (!rst && bus.word_valid_o && bus.word_ready_i) begin
            if (mq.size() < WORD_W) begin
                check("word_without_model_bits", 64'(mq.size()), 64'(WORD_W));
            end else begin
                exp_w = '0;
                for (int i = 0; i < WORD_W; i++) exp_w = {exp_w[WORD_W-2:0], mq.pop_front()};
                check("word", 64'(bus.word_o), 64'(exp_w));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [127:0] c, input int n);
        bit hs;
        int guard = 0;
        bus.cavlc_enc_valid      = 1'b1;
        bus.cavlc_bitstream_code = c;
        bus.cavlc_bitstream_bit  = 7'(n);
        forever begin
            @(negedge clk);
            hs = bus.packer_ready;
            step();
            if (hs) break;
            if (++guard > 2000) begin
                check("send_code_timeout", 64'(guard), 64'(0));
                break;
            end
        end
        bus.cavlc_enc_valid = 1'b0;
    endtask

    task automatic flush_req();
        bit hs;
        int guard = 0;
        bus.flush_i = 1'b1;
        forever begin
            @(negedge clk);
            hs = bus.flush_ready_o;
            step();
            if (hs) break;
            if (++guard > 2000) begin
                check("flush_req_timeout", 64'(guard), 64'(0));
                break;
            end
        end
        bus.flush_i = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        forever begin
            @(negedge clk);
            if (bus.flush_done_o) break;
            if (++guard > 3000) begin
                check("flush_done_timeout", 64'(guard), 64'(0));
                return;
            end
        end
        check("drained_model_bits", 64'(mq.size()), 64'(0));
        check("total_bytes_at_done", 64'(total_bytes), 64'((model_bits / 8) % (1 << 24)));
        @(negedge clk);
        check("flush_done_one_cycle", 64'(bus.flush_done_o), 64'(0));
        step();
    endtask

    initial begin
        int acc_cnt;
        int r;
        bus.cavlc_enc_valid      = 1'b0;
        bus.cavlc_bitstream_code = '0;
        bus.cavlc_bitstream_bit  = '0;
        bus.flush_i              = 1'b0;
        bus.word_ready_i         = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_packer_ready", 64'(bus.packer_ready), 64'(1));
        check("rst_flush_ready", 64'(bus.flush_ready_o), 64'(1));
        check("rst_flush_done", 64'(bus.flush_done_o), 64'(0));
        check("rst_word_valid", 64'(bus.word_valid_o), 64'(0));
        check("rst_word", 64'(bus.word_o), 64'(0));
        check("rst_total_bytes", 64'(total_bytes), 64'(0));
        step();

        // 3-bit code then flush: single word 0xB0000000
        send_code(128'b101, 3);
        flush_req();
        wait_done();
        check("total_after_first_flush", 64'(total_bytes), 64'(4));

        // two 16-bit codes complete a word one cycle after the second handshake
        send_code(128'hABCD, 16);
        send_code(128'h1234, 16);
        @(negedge clk);
        check("latency_word_valid", 64'(bus.word_valid_o), 64'(1));
        check("latency_word", 64'(bus.word_o), 64'(32'hABCD1234));
        step();

        // word-aligned flush: stop bit lands in a fresh word
        send_code(128'hDEADBEEF, 32);
        flush_req();
        wait_done();

        // backpressure: only two 127-bit codes fit while the output is stalled
        rdy_mode = 0;
        repeat (2) step();
        acc_cnt = 0;
        bus.cavlc_enc_valid      = 1'b1;
        bus.cavlc_bitstream_code = '1;
        bus.cavlc_bitstream_bit  = 7'd127;
        repeat (6) begin
            @(negedge clk);
            if (bus.packer_ready) acc_cnt++;
            step();
        end
        bus.cavlc_enc_valid = 1'b0;
        check("backpressure_accepted", 64'(acc_cnt), 64'(2));
        @(negedge clk);
        check("backpressure_ready_low", 64'(bus.packer_ready), 64'(0));
        check("backpressure_word_valid", 64'(bus.word_valid_o), 64'(1));
        step();
        rdy_mode = 1;
        repeat (3) send_code('1, 127);
        flush_req();
        wait_done();

        // zero-length codes interleaved with 5-bit codes
        for (int i = 0; i < 20; i++) begin
            send_code(128'($urandom), 5);
            send_code(128'($urandom), 0);
        end
        flush_req();
        wait_done();

        // randomized codes, gaps, flushes and output stalls
        rdy_mode = 2;
        repeat (300) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                flush_req();
                wait_done();
            end else if (r < 20) begin
                step();
            end else begin
                send_code({$urandom, $urandom, $urandom, $urandom},
                          (r < 35) ? $urandom_range(0, 8) : $urandom_range(0, 127));
            end
        end
        flush_req();
        wait_done();

        // reset while draining with words still pending
        rdy_mode = 0;
        repeat (2) step();
        send_code({$urandom, $urandom, $urandom, $urandom}, 70);
        flush_req();
        repeat (3) step();
        @(negedge clk);
        check("pre_reset_word_valid", 64'(bus.word_valid_o), 64'(1));
        check("pre_reset_flush_ready", 64'(bus.flush_ready_o), 64'(0));
        step();
        rst = 1'b1;
        mq.delete();
        model_bits = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_word_valid", 64'(bus.word_valid_o), 64'(0));
        check("post_reset_packer_ready", 64'(bus.packer_ready), 64'(1));
        check("post_reset_flush_ready", 64'(bus.flush_ready_o), 64'(1));
        check("post_reset_total_bytes", 64'(total_bytes), 64'(0));
        check("post_reset_word", 64'(bus.word_o), 64'(0));
        step();
        rdy_mode = 1;
        send_code(128'hABC, 12);
        flush_req();
        wait_done();
        check("total_after_reset_flush", 64'(total_bytes), 64'(4));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "global timeout");
    end
endmodule
